// File: rtl/brownout_dig_mc.sv
// brownout_dig_mc: multi-channel brownout supervisor digital core.
// Per channel: 2-flop synchroniser, debounce, one-shot hold-off FSM, sticky
// event flag and saturating event counter. Also trip-code decoders and
// RC-oscillator enable. Optional debug clock divider: define
// BROWNOUT_DBG_DIV_EN to build it; otherwise osc_ck_256 is tied low.
module brownout_dig_mc #(
    parameter int NCH     = 2,
    parameter int TRIP_W  = 3,
    parameter int CNT_W   = 16,
    parameter int SHORT_W = 12,
    parameter int DEB_W   = 4
) (
    input  logic                          osc_ck,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          force_rc_osc,
    input  logic                          force_short_oneshot,
    input  logic [DEB_W-1:0]              deb_cyc,
    input  logic [NCH-1:0]                brout_filt,
    input  logic [NCH-1:0]                clr_sticky,
    input  logic [TRIP_W-1:0]             otrip,
    input  logic [NCH*TRIP_W-1:0]         vtrip,
    output logic [(1<<TRIP_W)-1:0]        otrip_decoded,
    output logic [NCH*(1<<TRIP_W)-1:0]    vtrip_decoded,
    output logic                          osc_ena,
    output logic [NCH-1:0]                out_unbuf,
    output logic                          pwr_good_all,
    output logic [NCH-1:0]                timed_out,
    output logic [NCH-1:0]                sticky,
    output logic [NCH*8-1:0]              evt_cnt,
    output logic                          osc_ck_256
);
    localparam int DEC_W = 1 << TRIP_W;
    localparam int HI_W  = CNT_W - SHORT_W;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_START = 3'd1,
        ST_GOOD  = 3'd2,
        ST_TRIP  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    logic [NCH-1:0] good_vec;

    // Trip-code decoders (combinational one-hot)
    for (genvar gj = 0; gj < DEC_W; gj++) begin : g_odec
        assign otrip_decoded[gj] = (otrip == TRIP_W'(gj));
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        for (genvar gj = 0; gj < DEC_W; gj++) begin : g_vdec
            assign vtrip_decoded[gi*DEC_W + gj] = (vtrip[gi*TRIP_W +: TRIP_W] == TRIP_W'(gj));
        end

        logic             sync1_reg;
        logic             s_reg;
        logic             d_reg;
        logic [DEB_W-1:0] deb_cnt_reg;
        state_t           state_reg, state_next;
        logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_adv;
        logic [HI_W-1:0]  hi_inc;
        logic             start_cnt_reg, start_cnt_next;
        logic             evt;
        logic             sticky_reg;
        logic [7:0]       evt_cnt_reg;

        // Two-flop synchroniser for the asynchronous comparator output
        always_ff @(posedge osc_ck) begin
            if (rst) begin
                sync1_reg <= 1'b0;
                s_reg     <= 1'b0;
            end else begin
                sync1_reg <= brout_filt[gi];
                s_reg     <= sync1_reg;
            end
        end

        // Debounce: adopt s only after deb_cyc+1 consecutive differing samples
        always_ff @(posedge osc_ck) begin
            if (rst) begin
                d_reg       <= 1'b0;
                deb_cnt_reg <= '0;
            end else if (s_reg != d_reg) begin
                if (deb_cnt_reg == deb_cyc) begin
                    d_reg       <= s_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end

        // Hold-off FSM state, one-shot counter and start-delay register
        always_ff @(posedge osc_ck) begin
            if (rst) begin
                state_reg     <= ST_OFF;
                cnt_reg       <= '1;
                start_cnt_reg <= 1'b0;
            end else begin
                state_reg     <= state_next;
                cnt_reg       <= cnt_next;
                start_cnt_reg <= start_cnt_next;
            end
        end

        // Short mode bumps only the high counter field and fills the low bits
        assign hi_inc  = cnt_reg[CNT_W-1:SHORT_W] + HI_W'(1);
        assign cnt_adv = force_short_oneshot ? {hi_inc, {SHORT_W{1'b1}}}
                                             : cnt_reg + CNT_W'(1);

        // Next-state logic; evt flags an entry into TRIP that must be counted
        always_comb begin
            state_next     = state_reg;
            cnt_next       = cnt_reg;
            start_cnt_next = start_cnt_reg;
            evt            = 1'b0;
            if (!ena) begin
                state_next     = ST_OFF;
                cnt_next       = '1;
                start_cnt_next = 1'b0;
            end else begin
                case (state_reg)
                    ST_OFF: begin
                        state_next     = ST_START;
                        cnt_next       = '1;
                        start_cnt_next = 1'b0;
                    end
                    ST_START: begin
                        if (start_cnt_reg) begin
                            if (d_reg) begin
                                state_next = ST_TRIP;
                                cnt_next   = '0;
                            end else begin
                                state_next = ST_GOOD;
                            end
                        end else begin
                            start_cnt_next = 1'b1;
                        end
                    end
                    ST_GOOD: begin
                        if (d_reg) begin
                            state_next = ST_TRIP;
                            cnt_next   = '0;
                            evt        = 1'b1;
                        end
                    end
                    ST_TRIP: begin
                        cnt_next = '0;
                        if (!d_reg) state_next = ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (d_reg) begin
                            state_next = ST_TRIP;
                            cnt_next   = '0;
                            evt        = 1'b1;
                        end else begin
                            cnt_next = cnt_adv;
                            if (cnt_adv == '1) state_next = ST_GOOD;
                        end
                    end
                    default: begin
                        state_next = ST_OFF;
                        cnt_next   = '1;
                    end
                endcase
            end
        end

        // Sticky flag and saturating event counter; a same-cycle event wins over clear
        always_ff @(posedge osc_ck) begin
            if (rst) begin
                sticky_reg  <= 1'b0;
                evt_cnt_reg <= '0;
            end else if (clr_sticky[gi]) begin
                sticky_reg  <= evt;
                evt_cnt_reg <= evt ? 8'd1 : 8'd0;
            end else if (evt) begin
                sticky_reg <= 1'b1;
                if (evt_cnt_reg != 8'hFF) evt_cnt_reg <= evt_cnt_reg + 8'd1;
            end
        end

        assign good_vec[gi]          = (state_reg == ST_GOOD);
        assign out_unbuf[gi]         = good_vec[gi];
        assign timed_out[gi]         = good_vec[gi];
        assign sticky[gi]            = sticky_reg;
        assign evt_cnt[gi*8 +: 8]    = evt_cnt_reg;
    end

    assign pwr_good_all = &good_vec;
    assign osc_ena      = force_rc_osc | (ena & ((|brout_filt) | ~(&good_vec)));

`ifdef BROWNOUT_DBG_DIV_EN
    logic [6:0] div_cnt_reg;
    logic       div_clk_reg;

    // Debug divider: toggle on every 128-cycle wrap while enabled
    always_ff @(posedge osc_ck) begin
        if (rst) begin
            div_cnt_reg <= '0;
            div_clk_reg <= 1'b0;
        end else if (!ena) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 7'd1;
            if (div_cnt_reg == 7'h7F) div_clk_reg <= ~div_clk_reg;
        end
    end

    assign osc_ck_256 = div_clk_reg;
`else
    assign osc_ck_256 = 1'b0;
`endif

endmodule

// File: tb/tb_brownout_dig_mc.sv
// Directed testbench for brownout_dig_mc (default parameters).
module tb_brownout_dig_mc;
    localparam int NCH = 2, TRIP_W = 3, CNT_W = 16, SHORT_W = 12, DEB_W = 4;
    localparam int DEC_W = 8;

    logic                       osc_ck = 1'b0;
    logic                       rst;
    logic                       ena;
    logic                       force_rc_osc;
    logic                       force_short_oneshot;
    logic [DEB_W-1:0]           deb_cyc;
    logic [NCH-1:0]             brout_filt;
    logic [NCH-1:0]             clr_sticky;
    logic [TRIP_W-1:0]          otrip;
    logic [NCH*TRIP_W-1:0]      vtrip;
    logic [DEC_W-1:0]           otrip_decoded;
    logic [NCH*DEC_W-1:0]       vtrip_decoded;
    logic                       osc_ena;
    logic [NCH-1:0]             out_unbuf;
    logic                       pwr_good_all;
    logic [NCH-1:0]             timed_out;
    logic [NCH-1:0]             sticky;
    logic [NCH*8-1:0]           evt_cnt;
    logic                       osc_ck_256;

    int total = 0;
    int bad   = 0;

    always #5 osc_ck = ~osc_ck;

    brownout_dig_mc #(
        .NCH(NCH), .TRIP_W(TRIP_W), .CNT_W(CNT_W), .SHORT_W(SHORT_W), .DEB_W(DEB_W)
    ) dut (
        .osc_ck(osc_ck), .rst(rst), .ena(ena), .force_rc_osc(force_rc_osc),
        .force_short_oneshot(force_short_oneshot), .deb_cyc(deb_cyc),
        .brout_filt(brout_filt), .clr_sticky(clr_sticky), .otrip(otrip), .vtrip(vtrip),
        .otrip_decoded(otrip_decoded), .vtrip_decoded(vtrip_decoded), .osc_ena(osc_ena),
        .out_unbuf(out_unbuf), .pwr_good_all(pwr_good_all), .timed_out(timed_out),
        .sticky(sticky), .evt_cnt(evt_cnt), .osc_ck_256(osc_ck_256)
    );

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; force_rc_osc = 1'b0; force_short_oneshot = 1'b1;
        deb_cyc = '0; brout_filt = '0; clr_sticky = '0; otrip = '0; vtrip = '0;
        repeat (3) @(negedge osc_ck);
        rst = 1'b0;
        @(negedge osc_ck);
        total++; if (out_unbuf !== 2'b00) begin bad++; $display("FAIL reset_out got=%b exp=00", out_unbuf); end
        total++; if (pwr_good_all !== 1'b0) begin bad++; $display("FAIL reset_pga got=%b exp=0", pwr_good_all); end
        total++; if (timed_out !== 2'b00) begin bad++; $display("FAIL reset_to got=%b exp=00", timed_out); end
        total++; if (sticky !== 2'b00) begin bad++; $display("FAIL reset_sticky got=%b exp=00", sticky); end
        total++; if (evt_cnt !== 16'h0000) begin bad++; $display("FAIL reset_evt got=%h exp=0000", evt_cnt); end
        total++; if (osc_ck_256 !== 1'b0) begin bad++; $display("FAIL reset_div got=%b exp=0", osc_ck_256); end
        total++; if (osc_ena !== 1'b0) begin bad++; $display("FAIL reset_osc_ena got=%b exp=0", osc_ena); end
        $display("reset: out=%b sticky=%b evt=%h", out_unbuf, sticky, evt_cnt);
    endtask

    task automatic test_enable();
        ena = 1'b1;
        #1;
        total++; if (osc_ena !== 1'b1) begin bad++; $display("FAIL en_osc_ena_start got=%b exp=1", osc_ena); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge osc_ck);
            if (k < 3) begin
                total++; if (out_unbuf !== 2'b00) begin bad++; $display("FAIL en_early k=%0d got=%b exp=00", k, out_unbuf); end
            end else begin
                total++; if (out_unbuf !== 2'b11) begin bad++; $display("FAIL en_rise got=%b exp=11", out_unbuf); end
            end
        end
        total++; if (pwr_good_all !== 1'b1) begin bad++; $display("FAIL en_pga got=%b exp=1", pwr_good_all); end
        total++; if (timed_out !== 2'b11) begin bad++; $display("FAIL en_to got=%b exp=11", timed_out); end
        total++; if (osc_ena !== 1'b0) begin bad++; $display("FAIL en_osc_ena got=%b exp=0", osc_ena); end
        $display("enable: out=%b pga=%b osc_ena=%b", out_unbuf, pwr_good_all, osc_ena);
    endtask

    task automatic test_decoders();
        logic [7:0] one;
        logic [7:0] exp_o;
        logic [15:0] exp_v;
        one = 8'd1;
        for (int c = 0; c < 8; c++) begin
            otrip = 3'(c);
            vtrip = {3'(7 - c), 3'(c)};
            #1;
            exp_o = one << c;
            exp_v = {one << (7 - c), one << c};
            total++; if (otrip_decoded !== exp_o) begin bad++; $display("FAIL dec_otrip code=%0d got=%b exp=%b", c, otrip_decoded, exp_o); end
            total++; if (vtrip_decoded !== exp_v) begin bad++; $display("FAIL dec_vtrip code=%0d got=%b exp=%b", c, vtrip_decoded, exp_v); end
            $display("decode: code=%0d o=%b v=%b", c, otrip_decoded, vtrip_decoded);
        end
    endtask

    task automatic test_debounce();
        int low_seen, ch1_low, fall_n, rise_n;
        logic osc_at_fall, to_at_rise;
        deb_cyc = 4'd3; force_short_oneshot = 1'b1;
        @(negedge osc_ck);
        // 3-cycle glitch must be rejected
        low_seen = 0;
        brout_filt[0] = 1'b1;
        repeat (3) @(negedge osc_ck);
        brout_filt[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge osc_ck);
            if (!out_unbuf[0]) low_seen++;
        end
        total++; if (low_seen != 0) begin bad++; $display("FAIL deb_glitch low_cycles=%0d exp=0", low_seen); end
        total++; if (evt_cnt !== 16'h0000) begin bad++; $display("FAIL deb_glitch_evt got=%h exp=0000", evt_cnt); end
        $display("debounce glitch: low_cycles=%0d evt=%h", low_seen, evt_cnt);
        // 6-cycle pulse trips after 7 edges, recovers 22 edges after release
        fall_n = -1; rise_n = -1; ch1_low = 0; osc_at_fall = 1'b0; to_at_rise = 1'b0;
        brout_filt[0] = 1'b1;
        for (int k = 1; k <= 40 && rise_n < 0; k++) begin
            @(negedge osc_ck);
            if (k == 6) brout_filt[0] = 1'b0;
            if (!out_unbuf[1]) ch1_low++;
            if (fall_n < 0 && !out_unbuf[0]) begin
                fall_n = k; osc_at_fall = osc_ena;
            end else if (fall_n >= 0 && out_unbuf[0]) begin
                rise_n = k; to_at_rise = timed_out[0];
            end
        end
        total++; if (fall_n != 7) begin bad++; $display("FAIL deb_fall got=%0d exp=7", fall_n); end
        total++; if (rise_n != 28) begin bad++; $display("FAIL short_recover got=%0d exp=28", rise_n); end
        total++; if (to_at_rise !== 1'b1) begin bad++; $display("FAIL short_timed_out got=%b exp=1", to_at_rise); end
        total++; if (osc_at_fall !== 1'b1) begin bad++; $display("FAIL trip_osc_ena got=%b exp=1", osc_at_fall); end
        total++; if (evt_cnt !== 16'h0001) begin bad++; $display("FAIL deb_evt got=%h exp=0001", evt_cnt); end
        total++; if (sticky !== 2'b01) begin bad++; $display("FAIL deb_sticky got=%b exp=01", sticky); end
        total++; if (ch1_low != 0) begin bad++; $display("FAIL deb_ch1_indep low_cycles=%0d exp=0", ch1_low); end
        $display("debounce pulse: fall=%0d rise=%0d evt=%h sticky=%b", fall_n, rise_n, evt_cnt, sticky);
    endtask

    task automatic test_retrip_hold();
        int rise_n, early_high;
        deb_cyc = 4'd0; force_short_oneshot = 1'b1;
        @(negedge osc_ck);
        rise_n = -1; early_high = 0;
        brout_filt[1] = 1'b1;
        for (int k = 1; k <= 60 && rise_n < 0; k++) begin
            @(negedge osc_ck);
            if (k == 3) begin
                total++; if (out_unbuf[1] !== 1'b1) begin bad++; $display("FAIL retrip_prefall got=%b exp=1", out_unbuf[1]); end
            end
            if (k == 4) begin
                total++; if (out_unbuf[1] !== 1'b0) begin bad++; $display("FAIL retrip_fall got=%b exp=0", out_unbuf[1]); end
                brout_filt[1] = 1'b0;
            end
            if (k == 12) brout_filt[1] = 1'b1;
            if (k == 15) begin
                total++; if (evt_cnt[15:8] !== 8'd1) begin bad++; $display("FAIL retrip_evt_pre got=%0d exp=1", evt_cnt[15:8]); end
            end
            if (k == 16) begin
                total++; if (evt_cnt[15:8] !== 8'd2) begin bad++; $display("FAIL retrip_evt_post got=%0d exp=2", evt_cnt[15:8]); end
            end
            if (k == 18) brout_filt[1] = 1'b0;
            if (k > 4 && out_unbuf[1]) rise_n = k;
            if (k > 4 && k < 37 && out_unbuf[1]) early_high++;
        end
        total++; if (rise_n != 37) begin bad++; $display("FAIL retrip_recover got=%0d exp=37", rise_n); end
        total++; if (early_high != 0) begin bad++; $display("FAIL retrip_early_good cycles=%0d exp=0", early_high); end
        total++; if (sticky !== 2'b11) begin bad++; $display("FAIL retrip_sticky got=%b exp=11", sticky); end
        $display("retrip: rise=%0d evt=%h sticky=%b", rise_n, evt_cnt, sticky);
    endtask

    task automatic test_mode_switch();
        int rise_n;
        force_short_oneshot = 1'b0;
        @(negedge osc_ck);
        rise_n = -1;
        brout_filt[0] = 1'b1;
        for (int k = 1; k <= 5100 && rise_n < 0; k++) begin
            @(negedge osc_ck);
            if (k == 4) brout_filt[0] = 1'b0;
            if (k == 5008) force_short_oneshot = 1'b1;
            if (k > 4 && out_unbuf[0]) rise_n = k;
        end
        total++; if (rise_n != 5022) begin bad++; $display("FAIL mode_switch_recover got=%0d exp=5022", rise_n); end
        total++; if (evt_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL mode_switch_evt got=%0d exp=2", evt_cnt[7:0]); end
        $display("mode switch: rise=%0d evt0=%0d", rise_n, evt_cnt[7:0]);
    endtask

    task automatic test_saturation_clear();
        int rise_n;
        clr_sticky = 2'b01;
        @(negedge osc_ck);
        clr_sticky = 2'b00;
        total++; if (evt_cnt !== 16'h0200) begin bad++; $display("FAIL clr_evt got=%h exp=0200", evt_cnt); end
        total++; if (sticky !== 2'b10) begin bad++; $display("FAIL clr_sticky got=%b exp=10", sticky); end
        for (int p = 0; p < 300; p++) begin
            brout_filt[0] = 1'b1;
            repeat (2) @(negedge osc_ck);
            brout_filt[0] = 1'b0;
            repeat (2) @(negedge osc_ck);
        end
        rise_n = -1;
        for (int k = 1; k <= 100 && rise_n < 0; k++) begin
            @(negedge osc_ck);
            if (out_unbuf[0]) rise_n = k;
        end
        total++; if (rise_n < 0) begin bad++; $display("FAIL sat_recover got=timeout exp=good"); end
        total++; if (evt_cnt[7:0] !== 8'd255) begin bad++; $display("FAIL sat_evt got=%0d exp=255", evt_cnt[7:0]); end
        total++; if (sticky[0] !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", sticky[0]); end
        $display("saturation: evt0=%0d sticky=%b", evt_cnt[7:0], sticky);
        // clear coincident with an event
        brout_filt[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge osc_ck);
            if (k == 3) begin
                total++; if (evt_cnt[7:0] !== 8'd255) begin bad++; $display("FAIL clr_evt_pre got=%0d exp=255", evt_cnt[7:0]); end
                clr_sticky = 2'b01;
            end
            if (k == 4) begin
                clr_sticky = 2'b00;
                total++; if (sticky[0] !== 1'b1) begin bad++; $display("FAIL clr_evt_sticky got=%b exp=1", sticky[0]); end
                total++; if (evt_cnt[7:0] !== 8'd1) begin bad++; $display("FAIL clr_evt_cnt got=%0d exp=1", evt_cnt[7:0]); end
            end
        end
        brout_filt[0] = 1'b0;
        rise_n = -1;
        for (int k = 1; k <= 60 && rise_n < 0; k++) begin
            @(negedge osc_ck);
            if (out_unbuf[0]) rise_n = k;
        end
        total++; if (rise_n < 0) begin bad++; $display("FAIL clr_recover got=timeout exp=good"); end
        $display("clear+event: sticky=%b evt=%h", sticky, evt_cnt);
    endtask

    task automatic test_back_to_back();
        int rise_n;
        rise_n = -1;
        brout_filt = 2'b11;
        for (int k = 1; k <= 60 && rise_n < 0; k++) begin
            @(negedge osc_ck);
            if (k == 3) begin
                total++; if (pwr_good_all !== 1'b1) begin bad++; $display("FAIL both_prefall got=%b exp=1", pwr_good_all); end
            end
            if (k == 4) begin
                total++; if (out_unbuf !== 2'b00) begin bad++; $display("FAIL both_fall got=%b exp=00", out_unbuf); end
                total++; if (pwr_good_all !== 1'b0) begin bad++; $display("FAIL both_pga got=%b exp=0", pwr_good_all); end
                brout_filt = 2'b00;
            end
            if (k > 4 && out_unbuf == 2'b11) rise_n = k;
        end
        total++; if (rise_n != 23) begin bad++; $display("FAIL both_recover got=%0d exp=23", rise_n); end
        total++; if (evt_cnt !== 16'h0302) begin bad++; $display("FAIL both_evt got=%h exp=0302", evt_cnt); end
        $display("simultaneous: rise=%0d evt=%h", rise_n, evt_cnt);
    endtask

    task automatic test_ena_drop();
        brout_filt[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge osc_ck);
            if (k == 4) brout_filt[0] = 1'b0;
            if (k == 12) begin
                total++; if (out_unbuf !== 2'b10) begin bad++; $display("FAIL drop_pre got=%b exp=10", out_unbuf); end
                ena = 1'b0;
            end
            if (k == 13) begin
                total++; if (out_unbuf !== 2'b00) begin bad++; $display("FAIL drop_off got=%b exp=00", out_unbuf); end
                total++; if (timed_out !== 2'b00) begin bad++; $display("FAIL drop_to got=%b exp=00", timed_out); end
                total++; if (osc_ena !== 1'b0) begin bad++; $display("FAIL drop_osc_ena got=%b exp=0", osc_ena); end
                force_rc_osc = 1'b1;
                #1;
                total++; if (osc_ena !== 1'b1) begin bad++; $display("FAIL force_osc got=%b exp=1", osc_ena); end
                force_rc_osc = 1'b0;
            end
            if (k == 14) ena = 1'b1;
            if (k == 16) begin
                total++; if (out_unbuf !== 2'b00) begin bad++; $display("FAIL reen_early got=%b exp=00", out_unbuf); end
            end
            if (k == 17) begin
                total++; if (out_unbuf !== 2'b11) begin bad++; $display("FAIL reen_rise got=%b exp=11", out_unbuf); end
            end
        end
        total++; if (evt_cnt !== 16'h0303) begin bad++; $display("FAIL drop_evt got=%h exp=0303", evt_cnt); end
        $display("ena drop: out=%b evt=%h", out_unbuf, evt_cnt);
    endtask

    task automatic test_debug_div();
`ifdef BROWNOUT_DBG_DIV_EN
        int t0, t1, t2, n;
        logic prev;
        t0 = -1; t1 = -1; t2 = -1; n = 0;
        prev = osc_ck_256;
        for (int k = 1; k <= 700 && t2 < 0; k++) begin
            @(negedge osc_ck);
            if (osc_ck_256 !== prev) begin
                if (n == 0) t0 = k; else if (n == 1) t1 = k; else t2 = k;
                n++;
            end
            prev = osc_ck_256;
        end
        total++; if (t1 - t0 != 128) begin bad++; $display("FAIL div_half got=%0d exp=128", t1 - t0); end
        total++; if (t2 - t0 != 256) begin bad++; $display("FAIL div_period got=%0d exp=256", t2 - t0); end
        $display("debug div: half=%0d period=%0d", t1 - t0, t2 - t0);
`else
        int high_seen;
        high_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge osc_ck);
            if (osc_ck_256 !== 1'b0) high_seen++;
        end
        total++; if (high_seen != 0) begin bad++; $display("FAIL div_tied cycles=%0d exp=0", high_seen); end
        $display("debug div disabled: nonzero_cycles=%0d", high_seen);
`endif
    endtask

    initial begin
        test_reset();
        test_enable();
        test_decoders();
        test_debounce();
        test_retrip_hold();
        test_mode_switch();
        test_saturation_clear();
        test_back_to_back();
        test_ena_drop();
        test_debug_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
